// File: rtl/sta_pkg.sv
// Shared types and default constants for the signature-capture compactors.
package sta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_state_t;

    // One clock's worth of circuit response, MSB-first as it lands in the MISR.
    typedef struct packed {
        logic in3;
        logic in2;
        logic in1;
    } sc_resp_t;

    localparam int unsigned SC_RESP_W = 3;
    localparam int unsigned SC_WIDTH  = 16;
    localparam logic [15:0] SC_POLY   = 16'h1021;
    localparam logic [15:0] SC_SEED   = 16'h0000;
    localparam int unsigned SC_CYCLES = 256;
    localparam int unsigned SC_CNT_W  = 16;

endpackage

// File: rtl/misr_step.sv
// Combinational next-state function of a multiple-input signature register.
module misr_step
    import sta_pkg::*;
#(
    parameter int unsigned       WIDTH = SC_WIDTH,
    parameter logic [WIDTH-1:0]  POLY  = WIDTH'(SC_POLY)
) (
    input  logic [WIDTH-1:0]     sig,
    input  logic [SC_RESP_W-1:0] din,
    output logic [WIDTH-1:0]     sig_next_c
);

    logic [WIDTH-1:0] shifted_c;
    logic [WIDTH-1:0] fb_c;

    // Shift left, fold the ejected MSB back through the polynomial, then inject responses.
    always_comb begin
        shifted_c  = {sig[WIDTH-2:0], 1'b0};
        fb_c       = sig[WIDTH-1] ? POLY : '0;
        sig_next_c = shifted_c ^ fb_c ^ WIDTH'(din);
    end

endmodule

// File: rtl/sig_compactor.sv
// Windowed MISR capture of out1/out2/out3 with start/busy/done handshake.
// Optional signature comparator (exp_sig/pass) enabled by defining SIG_CMP_EN.
module sig_compactor
    import sta_pkg::*;
#(
    parameter int unsigned      WIDTH  = SC_WIDTH,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(SC_POLY),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(SC_SEED),
    parameter int unsigned      CYCLES = SC_CYCLES,
    parameter int unsigned      CNT_W  = SC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in1,
    input  logic             in2,
    input  logic             in3,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sig
`ifdef SIG_CMP_EN
    ,
    input  logic [WIDTH-1:0] exp_sig,
    output logic             pass
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

    sc_state_t        state;
    sc_state_t        state_next;
    sc_resp_t         resp_c;
    logic [WIDTH-1:0] sig_step_c;
    logic [WIDTH-1:0] sig_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_d;
    logic             done_d;
`ifdef SIG_CMP_EN
    logic             pass_d;
`endif

    assign resp_c = '{in3: in3, in2: in2, in1: in1};

    misr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr_step (
        .sig        (sig),
        .din        (resp_c),
        .sig_next_c (sig_step_c)
    );

    // State, signature, counter and all outputs share one register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sig   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SIG_CMP_EN
            pass  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            sig   <= sig_d;
            cnt   <= cnt_d;
            busy  <= busy_d;
            done  <= done_d;
`ifdef SIG_CMP_EN
            pass  <= pass_d;
`endif
        end
    end

    // Next-state and next-output logic; everything holds unless a branch says otherwise.
    always_comb begin
        state_next = state;
        sig_d      = sig;
        cnt_d      = cnt;
        busy_d     = busy;
        done_d     = done;
`ifdef SIG_CMP_EN
        pass_d     = pass;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    sig_d      = SEED;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
`ifdef SIG_CMP_EN
                    pass_d     = 1'b0;
`endif
                end
            end
            RUN: begin
                sig_d = sig_step_c;
                cnt_d = cnt + CNT_W'(1);
                // start is deliberately not looked at here, even on the final edge.
                if (cnt == LAST_CNT) begin
                    state_next = DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
`ifdef SIG_CMP_EN
                    pass_d     = (sig_step_c == exp_sig);
`endif
                end
            end
            default: begin
                state_next = IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sig_compactor.sv
// Directed bench for sig_compactor: two 8-bit instances (seed 00 / 80) and one default instance.
module tb_sig_compactor;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [2:0] din_a = 3'b000, din_b = 3'b000;
    logic       zero  = 1'b0;

    logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
    logic [7:0]  sig_a, sig_b;
    logic [15:0] sig_c;
`ifdef SIG_CMP_EN
    logic [7:0]  exp_a = 8'h00, exp_b = 8'h00;
    logic [15:0] exp_c = 16'h0000;
    logic        pass_a, pass_b, pass_c;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sig_compactor #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .CYCLES(4), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .in1(din_a[0]), .in2(din_a[1]), .in3(din_a[2]),
        .busy(busy_a), .done(done_a), .sig(sig_a)
`ifdef SIG_CMP_EN
        , .exp_sig(exp_a), .pass(pass_a)
`endif
    );

    sig_compactor #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h80), .CYCLES(4), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .in1(din_b[0]), .in2(din_b[1]), .in3(din_b[2]),
        .busy(busy_b), .done(done_b), .sig(sig_b)
`ifdef SIG_CMP_EN
        , .exp_sig(exp_b), .pass(pass_b)
`endif
    );

    sig_compactor u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c),
        .in1(zero), .in2(zero), .in3(zero),
        .busy(busy_c), .done(done_c), .sig(sig_c)
`ifdef SIG_CMP_EN
        , .exp_sig(exp_c), .pass(pass_c)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    typedef struct {
        bit         sel;    // 0 -> u_a, 1 -> u_b
        bit         start;
        logic [2:0] din;    // {in3, in2, in1}
        bit         busy;
        bit         done;
        logic [7:0] sig;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [7:0] s5_sig  [7];
        bit         s5_busy [7];
        bit         s5_done [7];
        int         edges;
        bit         nonzero;

        vecs = '{
            '{1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 8'h00},
            '{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 8'h01},
            '{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 8'h03},
            '{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 8'h07},
            '{1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 8'h0F},
            '{1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 8'h0F},
            '{1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 8'h80},
            '{1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 8'h19},
            '{1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 8'h36},
            '{1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 8'h68},
            '{1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 8'hD4},
            '{1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 8'hD4},
            '{1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 8'h00},
            '{1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 8'h07},
            '{1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 8'h09},
            '{1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 8'h15},
            '{1'b0, 1'b0, 3'b111, 0, 1'b1, 8'h2D}
        };
        s5_sig  = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h00, 8'h01};
        s5_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        s5_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state, observed while rst_n is still low.
        #12;
        chk("reset sig_a", 32'(sig_a), 32'h0);
        chk("reset busy_a", 32'(busy_a), 32'h0);
        chk("reset done_a", 32'(done_a), 32'h0);
        chk("reset sig_b", 32'(sig_b), 32'h0);
        chk("reset sig_c", 32'(sig_c), 32'h0);
`ifdef SIG_CMP_EN
        chk("reset pass_a", 32'(pass_a), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table: scenario 2, scenario 3, then a restart of u_a from DONE with all inputs high.
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].sel == 1'b0) begin
                start_a = vecs[i].start;
                din_a   = vecs[i].din;
                start_b = 1'b0;
            end else begin
                start_b = vecs[i].start;
                din_b   = vecs[i].din;
                start_a = 1'b0;
            end
            @(posedge clk);
            #1;
            if (vecs[i].sel == 1'b0) begin
                chk($sformatf("vec%0d sig_a", i), 32'(sig_a), 32'(vecs[i].sig));
                chk($sformatf("vec%0d busy_a", i), 32'(busy_a), 32'(vecs[i].busy));
                chk($sformatf("vec%0d done_a", i), 32'(done_a), 32'(vecs[i].done));
            end else begin
                chk($sformatf("vec%0d sig_b", i), 32'(sig_b), 32'(vecs[i].sig));
                chk($sformatf("vec%0d busy_b", i), 32'(busy_b), 32'(vecs[i].busy));
                chk($sformatf("vec%0d done_b", i), 32'(done_b), 32'(vecs[i].done));
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;

        // Reset mid-run must clear outputs with no clock edge, then stay idle.
        din_a   = 3'b001;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        chk("midrun pre-reset sig_a", 32'(sig_a), 32'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset sig_a", 32'(sig_a), 32'h0);
        chk("async reset busy_a", 32'(busy_a), 32'h0);
        chk("async reset done_a", 32'(done_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle after reset busy_a", 32'(busy_a), 32'h0);
        chk("idle after reset sig_a", 32'(sig_a), 32'h0);
        chk("idle after reset done_a", 32'(done_a), 32'h0);

        // start held high: ignored in RUN, restarts on the edge after done.
        start_a = 1'b1;
        din_a   = 3'b001;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            chk($sformatf("held start e%0d sig_a", k), 32'(sig_a), 32'(s5_sig[k]));
            chk($sformatf("held start e%0d busy_a", k), 32'(busy_a), 32'(s5_busy[k]));
            chk($sformatf("held start e%0d done_a", k), 32'(done_a), 32'(s5_done[k]));
        end
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("held start final done_a", 32'(done_a), 32'h1);

        // Default instance: 256-update window of zeros.
        start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        chk("default busy_c after start", 32'(busy_c), 32'h1);
        edges   = 0;
        nonzero = 1'b0;
        while (!done_c && edges < 300) begin
            @(posedge clk); #1;
            edges++;
            if (sig_c != 16'h0) nonzero = 1'b1;
        end
        chk("default done latency", 32'(edges), 32'd256);
        chk("default sig stayed zero", 32'(nonzero), 32'h0);
        chk("default busy_c at done", 32'(busy_c), 32'h0);

`ifdef SIG_CMP_EN
        // Comparator: matching then non-matching expected signature.
        for (int r = 0; r < 2; r++) begin
            exp_a   = (r == 0) ? 8'h0F : 8'h0E;
            din_a   = 3'b001;
            start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            chk($sformatf("cmp%0d pass cleared on start", r), 32'(pass_a), 32'h0);
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("cmp%0d done_a", r), 32'(done_a), 32'h1);
            chk($sformatf("cmp%0d pass_a", r), 32'(pass_a), (r == 0) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
            chk($sformatf("cmp%0d pass_a held", r), 32'(pass_a), (r == 0) ? 32'h1 : 32'h0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
